// File: rtl/route_reservation_arbiter_if.sv
// ----------------------------------------------------------------------------
// route_reservation_arbiter_if
//
// Bundle between the per-port control logic of an N-port mesh router and the
// switch allocator.
//
//   routeReserveRequestValid [N]        per input: requesting an output (level)
//   routeReserveRequest      [N*RW]     per input: requested output index
//   routeRelieve             [N]        per input: release held output (pulse)
//   routeReserveStatus       [N]        per input: currently holds an output
//   xbarSelect               [N*RW]     per output: owning input index, 0 if free
//   outputBusy               [N]        per output: reserved
//
// master = port control side, slave = allocator side.
// ----------------------------------------------------------------------------
interface route_reservation_arbiter_if #(
    parameter int N             = 4,
    parameter int REQUEST_WIDTH = 2
);
    logic [N-1:0]               routeReserveRequestValid;
    logic [N*REQUEST_WIDTH-1:0] routeReserveRequest;
    logic [N-1:0]               routeRelieve;
    logic [N-1:0]               routeReserveStatus;
    logic [N*REQUEST_WIDTH-1:0] xbarSelect;
    logic [N-1:0]               outputBusy;

    modport master (
        output routeReserveRequestValid,
        output routeReserveRequest,
        output routeRelieve,
        input  routeReserveStatus,
        input  xbarSelect,
        input  outputBusy
    );

    modport slave (
        input  routeReserveRequestValid,
        input  routeReserveRequest,
        input  routeRelieve,
        output routeReserveStatus,
        output xbarSelect,
        output outputBusy
    );
endinterface

// File: rtl/route_reservation_arbiter.sv
// ----------------------------------------------------------------------------
// route_reservation_arbiter
//
// Switch-side allocator for an N-port mesh router. Every output runs its own
// FREE/BUSY state machine: while FREE it grants the first eligible input found
// by a round-robin scan starting at its pointer; while BUSY it holds the owner
// until that owner pulses routeRelieve, then moves its pointer just past the
// departing owner.
//
// Ports:
//   clk  - system clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - route_reservation_arbiter_if.slave (requests in, status/xbar out)
// ----------------------------------------------------------------------------
module route_reservation_arbiter #(
    parameter int N             = 4,
    parameter int REQUEST_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    route_reservation_arbiter_if.slave   bus
);

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } outState_t;

    outState_t                stateQ [N];
    logic [REQUEST_WIDTH-1:0] ownQ   [N];
    logic [REQUEST_WIDTH-1:0] ptrQ   [N];
    logic [N-1:0]             statusQ;

    logic [REQUEST_WIDTH-1:0] reqField [N];
    logic [N-1:0]             eligible [N];
    logic [REQUEST_WIDTH:0]   pick     [N];   // {found, index}
    logic [N-1:0]             relieveHit;

    // Round-robin scan: walk from ptr upward modulo N; walking the offsets in
    // reverse lets the lowest offset (the first in scan order) overwrite last.
    function automatic logic [REQUEST_WIDTH:0] rrPick(
        input logic [N-1:0]               elig,
        input logic [REQUEST_WIDTH-1:0]   ptr
    );
        logic [REQUEST_WIDTH:0] result;
        int                     idx;
        result = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (elig[idx]) result = {1'b1, REQUEST_WIDTH'(idx)};
        end
        return result;
    endfunction

    // Arbitration: an input is eligible only for the output it names, and only
    // while it holds nothing. Because each input names one output, winners of
    // different outputs are always distinct inputs. Indices >= N match no
    // output and are therefore never granted.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            reqField[i] = bus.routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH];
        end
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                eligible[o][i] = bus.routeReserveRequestValid[i]
                              && (reqField[i] == REQUEST_WIDTH'(o))
                              && !statusQ[i];
            end
            pick[o]       = rrPick(eligible[o], ptrQ[o]);
            relieveHit[o] = (stateQ[o] == BUSY) && bus.routeRelieve[ownQ[o]];
        end
    end

    // State update: grant and relieve never touch the same input in one cycle
    // (a grant needs status 0, a relieve needs status 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < N; o++) begin
                stateQ[o] <= FREE;
                ownQ[o]   <= '0;
                ptrQ[o]   <= '0;
            end
            statusQ <= '0;
        end else begin
            for (int o = 0; o < N; o++) begin
                case (stateQ[o])
                    FREE: begin
                        if (pick[o][REQUEST_WIDTH]) begin
                            stateQ[o] <= BUSY;
                            ownQ[o]   <= pick[o][REQUEST_WIDTH-1:0];
                            statusQ[pick[o][REQUEST_WIDTH-1:0]] <= 1'b1;
                        end
                    end
                    BUSY: begin
                        if (relieveHit[o]) begin
                            stateQ[o] <= FREE;
                            ownQ[o]   <= '0;   // free outputs present select 0
                            ptrQ[o]   <= (ownQ[o] == REQUEST_WIDTH'(N - 1))
                                         ? '0 : ownQ[o] + 1'b1;
                            statusQ[ownQ[o]] <= 1'b0;
                        end
                    end
                    default: stateQ[o] <= FREE;
                endcase
            end
        end
    end

    always_comb begin
        bus.routeReserveStatus = statusQ;
        for (int o = 0; o < N; o++) begin
            bus.outputBusy[o]                                 = (stateQ[o] == BUSY);
            bus.xbarSelect[o*REQUEST_WIDTH +: REQUEST_WIDTH]  = ownQ[o];
        end
    end

endmodule

// File: tb/tb_route_reservation_arbiter.sv
// ----------------------------------------------------------------------------
// tb_route_reservation_arbiter
//
// Drives a 4-port and a 3-port allocator side by side. A behavioural model
// (owner per output, held output per input, pointer per output) predicts
// status, busy and crossbar selects every cycle; directed sequences add
// fixed-value checks on top of the model.
// ----------------------------------------------------------------------------
module tb_route_reservation_arbiter;

    localparam int N0 = 4;
    localparam int W0 = 2;
    localparam int N1 = 3;
    localparam int W1 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    route_reservation_arbiter_if #(.N(N0), .REQUEST_WIDTH(W0)) bus0 ();
    route_reservation_arbiter_if #(.N(N1), .REQUEST_WIDTH(W1)) bus1 ();

    route_reservation_arbiter #(.N(N0), .REQUEST_WIDTH(W0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    route_reservation_arbiter #(.N(N1), .REQUEST_WIDTH(W1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus per DUT/input.
    int vValid [2][4];
    int vReq   [2][4];
    int vRel   [2][4];
    int rstReq;

    // Model: owner of each output (-1 free), pointer of each output,
    // output held by each input (-1 none).
    int mOwner [2][4];
    int mPtr   [2][4];
    int mHeld  [2][4];
    int nPorts [2] = '{4, 3};

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyInputs();
        rst = rstReq[0];
        for (int i = 0; i < N0; i++) begin
            bus0.routeReserveRequestValid[i] = vValid[0][i][0];
            bus0.routeReserveRequest[i*W0 +: W0] = W0'(vReq[0][i]);
            bus0.routeRelieve[i] = vRel[0][i][0];
        end
        for (int i = 0; i < N1; i++) begin
            bus1.routeReserveRequestValid[i] = vValid[1][i][0];
            bus1.routeReserveRequest[i*W1 +: W1] = W1'(vReq[1][i]);
            bus1.routeRelieve[i] = vRel[1][i][0];
        end
    endtask

    task automatic modelStep(input int d);
        int n;
        int gIn [4];
        int rOut [4];
        int idx;
        n = nPorts[d];
        if (rstReq != 0) begin
            for (int o = 0; o < 4; o++) begin
                mOwner[d][o] = -1;
                mPtr[d][o]   = 0;
                mHeld[d][o]  = -1;
            end
            return;
        end
        for (int o = 0; o < 4; o++) begin
            gIn[o]  = -1;
            rOut[o] = 0;
        end
        for (int o = 0; o < n; o++) begin
            if (mOwner[d][o] < 0) begin
                for (int k = 0; k < n; k++) begin
                    idx = (mPtr[d][o] + k) % n;
                    if (gIn[o] < 0 && vValid[d][idx] != 0 && vReq[d][idx] == o && mHeld[d][idx] < 0)
                        gIn[o] = idx;
                end
            end else if (vRel[d][mOwner[d][o]] != 0) begin
                rOut[o] = 1;
            end
        end
        for (int o = 0; o < n; o++) begin
            if (gIn[o] >= 0) begin
                mOwner[d][o]      = gIn[o];
                mHeld[d][gIn[o]]  = o;
            end
            if (rOut[o] != 0) begin
                mHeld[d][mOwner[d][o]] = -1;
                mPtr[d][o]             = (mOwner[d][o] + 1) % n;
                mOwner[d][o]           = -1;
            end
        end
    endtask

    task automatic compareModel();
        logic [7:0] expStat, expBusy, expX;
        for (int d = 0; d < 2; d++) begin
            expStat = '0;
            expBusy = '0;
            expX    = '0;
            for (int i = 0; i < nPorts[d]; i++)
                if (mHeld[d][i] >= 0) expStat[i] = 1'b1;
            for (int o = 0; o < nPorts[d]; o++)
                if (mOwner[d][o] >= 0) begin
                    expBusy[o] = 1'b1;
                    expX = expX | (8'(mOwner[d][o]) << (2 * o));
                end
            if (d == 0) begin
                checkVal("m0.status", 32'(bus0.routeReserveStatus), 32'(expStat));
                checkVal("m0.busy",   32'(bus0.outputBusy),         32'(expBusy));
                checkVal("m0.xbar",   32'(bus0.xbarSelect),         32'(expX));
            end else begin
                checkVal("m1.status", 32'(bus1.routeReserveStatus), 32'(expStat));
                checkVal("m1.busy",   32'(bus1.outputBusy),         32'(expBusy));
                checkVal("m1.xbar",   32'(bus1.xbarSelect),         32'(expX));
            end
        end
    endtask

    // One clock: drive on the falling edge, model on the rising edge, compare
    // just after it.
    task automatic cycle();
        @(negedge clk);
        applyInputs();
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        compareModel();
    endtask

    task automatic clearStim();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                vValid[d][i] = 0;
                vReq[d][i]   = 0;
                vRel[d][i]   = 0;
            end
    endtask

    int rrExp [4] = '{0, 1, 3, 0};
    int owner;
    bit seen;

    initial begin
        rst = 1'b1;
        clearStim();
        rstReq = 1;
        applyInputs();

        // Reset and idle
        cycle();
        cycle();
        rstReq = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            checkVal("idle.status", 32'(bus0.routeReserveStatus), 32'h0);
            checkVal("idle.busy",   32'(bus0.outputBusy),         32'h0);
            checkVal("idle.xbar",   32'(bus0.xbarSelect),         32'h0);
        end

        // Single grant: input 2 -> output 3, relieve 5 cycles later
        vValid[0][2] = 1; vReq[0][2] = 3;
        cycle();
        checkVal("single.status", 32'(bus0.routeReserveStatus), 32'h4);
        checkVal("single.busy",   32'(bus0.outputBusy),         32'h8);
        checkVal("single.xbar3",  32'(bus0.xbarSelect[7:6]),    32'h2);
        cycle(); cycle(); cycle(); cycle();
        checkVal("single.hold",   32'(bus0.routeReserveStatus), 32'h4);
        vValid[0][2] = 0; vRel[0][2] = 1;
        cycle();
        vRel[0][2] = 0;
        checkVal("single.relStatus", 32'(bus0.routeReserveStatus), 32'h0);
        checkVal("single.relBusy",   32'(bus0.outputBusy),         32'h0);
        checkVal("single.relXbar",   32'(bus0.xbarSelect),         32'h0);

        // Round-robin on output 1 among inputs 0, 1, 3
        vValid[0][0] = 1; vReq[0][0] = 1;
        vValid[0][1] = 1; vReq[0][1] = 1;
        vValid[0][3] = 1; vReq[0][3] = 1;
        for (int g = 0; g < 4; g++) begin
            seen = 1'b0;
            for (int w = 0; w < 10 && !seen; w++) begin
                cycle();
                if (bus0.outputBusy[1]) seen = 1'b1;
            end
            checkVal("rr.grant", seen ? 32'(bus0.xbarSelect[3:2]) : 32'hFF, 32'(rrExp[g]));
            if (seen) begin
                owner = int'(bus0.xbarSelect[3:2]);
                cycle(); cycle();
                vRel[0][owner] = 1;
                cycle();
                vRel[0][owner] = 0;
            end
        end
        clearStim();
        cycle();

        // Contention on output 2 plus a parallel grant on output 0
        vValid[0][0] = 1; vReq[0][0] = 2;
        vValid[0][1] = 1; vReq[0][1] = 2;
        vValid[0][3] = 1; vReq[0][3] = 0;
        cycle();
        checkVal("cont.status", 32'(bus0.routeReserveStatus), 32'h9);
        checkVal("cont.xbar2",  32'(bus0.xbarSelect[5:4]),    32'h0);
        checkVal("cont.xbar0",  32'(bus0.xbarSelect[1:0]),    32'h3);
        vValid[0][0] = 0; vValid[0][3] = 0; vRel[0][0] = 1;
        cycle();
        vRel[0][0] = 0;
        checkVal("cont.dead",   32'(bus0.outputBusy[2]),      32'h0);
        cycle();
        checkVal("cont.next",   32'(bus0.xbarSelect[5:4]),    32'h1);
        checkVal("cont.status2", 32'(bus0.routeReserveStatus), 32'hA);
        vValid[0][1] = 0; vRel[0][1] = 1; vRel[0][3] = 1;
        cycle();
        clearStim();
        cycle();

        // Reset while two outputs are busy; output 2 pointer returns to 0
        vValid[0][0] = 1; vReq[0][0] = 1;
        vValid[0][3] = 1; vReq[0][3] = 0;
        cycle();
        checkVal("rstmid.busy", 32'(bus0.outputBusy), 32'h3);
        clearStim();
        rstReq = 1;
        cycle();
        rstReq = 0;
        checkVal("rstmid.status", 32'(bus0.routeReserveStatus), 32'h0);
        checkVal("rstmid.busy0",  32'(bus0.outputBusy),         32'h0);
        checkVal("rstmid.xbar",   32'(bus0.xbarSelect),         32'h0);
        vValid[0][1] = 1; vReq[0][1] = 2;
        vValid[0][3] = 1; vReq[0][3] = 2;
        cycle();
        checkVal("rstmid.lowest", 32'(bus0.xbarSelect[5:4]), 32'h1);
        clearStim();
        vRel[0][1] = 1;
        cycle();
        clearStim();
        cycle();

        // 3-port instance: illegal index, stray relieve, holder asking again
        vValid[1][0] = 1; vReq[1][0] = 3;
        for (int c = 0; c < 5; c++) begin
            cycle();
            checkVal("n3.illegal", 32'(bus1.routeReserveStatus), 32'h0);
        end
        vValid[1][0] = 0;
        vRel[1][1] = 1;
        cycle();
        vRel[1][1] = 0;
        checkVal("n3.stray", 32'(bus1.outputBusy), 32'h0);
        vValid[1][2] = 1; vReq[1][2] = 0;
        cycle();
        checkVal("n3.hold", 32'(bus1.routeReserveStatus), 32'h4);
        vReq[1][2] = 1;
        cycle(); cycle();
        checkVal("n3.noSecond", 32'(bus1.outputBusy), 32'h1);
        vValid[1][2] = 0; vRel[1][2] = 1;
        cycle();
        clearStim();
        cycle();

        // Randomized traffic on both instances, occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < nPorts[d]; i++) begin
                    vValid[d][i] = ($urandom_range(0, 9) < 6) ? 1 : 0;
                    vReq[d][i]   = int'($urandom_range(0, 3));
                    vRel[d][i]   = ($urandom_range(0, 3) == 0) ? 1 : 0;
                end
            rstReq = ($urandom_range(0, 199) == 0) ? 1 : 0;
            cycle();
        end
        rstReq = 0;
        clearStim();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
